// File: rtl/core_csr_regfile_pkg.sv
// Shared definitions for the machine-mode CSR register file: CSR addresses,
// mstatus field positions, the fixed misa value and the CSR op encoding.
package core_csr_regfile_pkg;

  localparam int unsigned CoreXlen    = 32;
  localparam int unsigned CorePcWidth = 32;

  // CSR addresses
  localparam logic [11:0] CsrMstatus   = 12'h300;
  localparam logic [11:0] CsrMisa      = 12'h301;
  localparam logic [11:0] CsrMtvec     = 12'h305;
  localparam logic [11:0] CsrMscratch  = 12'h340;
  localparam logic [11:0] CsrMepc      = 12'h341;
  localparam logic [11:0] CsrMcause    = 12'h342;
  localparam logic [11:0] CsrMcycle    = 12'hB00;
  localparam logic [11:0] CsrMinstret  = 12'hB02;
  localparam logic [11:0] CsrMcycleh   = 12'hB80;
  localparam logic [11:0] CsrMinstreth = 12'hB82;
  localparam logic [11:0] CsrMhartid   = 12'hF14;

  // mstatus field positions
  localparam int unsigned MstatusMieBit  = 3;
  localparam int unsigned MstatusMpieBit = 7;
  localparam int unsigned MstatusMppLo   = 11;
  localparam int unsigned MstatusMppHi   = 12;

  // RV32I, machine mode only
  localparam logic [31:0] MisaValue = 32'h4000_0100;

  typedef enum logic [1:0] {
    CsrOpNone = 2'b00,
    CsrOpRw   = 2'b01,
    CsrOpRs   = 2'b10,
    CsrOpRc   = 2'b11
  } csr_op_e;

endpackage

// File: rtl/core_csr_regfile_if.sv
// CSR access bus between the execute stage (master) and the CSR register
// file (slave).
//   csr_rd_en/csr_wr_en : access request, csr_op : RW/RS/RC/none
//   csr_addr, csr_wdata : address and operand
//   csr_rdata           : old value of the addressed CSR (combinational)
//   csr_illegal         : access to an unimplemented or read-only CSR
interface core_csr_regfile_if #(
  parameter int unsigned XLEN = core_csr_regfile_pkg::CoreXlen
) ();

  logic            csr_rd_en;
  logic            csr_wr_en;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;

  modport master (
    output csr_rd_en, csr_wr_en, csr_op, csr_addr, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_rd_en, csr_wr_en, csr_op, csr_addr, csr_wdata,
    output csr_rdata, csr_illegal
  );

endinterface

// File: rtl/core_csr_counter64.sv
// 64-bit free-running counter with separate low/high write ports.
//   clk, rst_n : clock, synchronous active-low reset
//   inc_i      : count this cycle
//   wr_lo_i    : load wdata_i into bits [31:0]
//   wr_hi_i    : load wdata_i into bits [63:32]
//   cnt_o      : current count
// Any write suppresses the increment for that cycle; the unwritten half
// keeps its value with no carry applied.
module core_csr_counter64 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]  = wdata_i;
      if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/core_csr_regfile.sv
// Machine-mode CSR register file.
//   clk, rst_n        : clock, synchronous active-low reset
//   csr_bus (slave)   : CSR read/modify/write access from execute
//   cmt_*             : trap commit strobes and data from the exception block
//   mret_en           : mret retiring
//   instr_retire      : one instruction retired this cycle
//   csr_mtvec         : trap target for fetch redirect
//   csr_mepc          : mret target for fetch redirect
//   csr_mie           : mstatus.MIE
// Register update priority: trap commit > mret > CSR instruction write.
module core_csr_regfile
  import core_csr_regfile_pkg::*;
#(
  parameter int unsigned     XLEN        = CoreXlen,
  parameter int unsigned     PC_WIDTH    = CorePcWidth,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0,
  parameter logic [XLEN-1:0] HART_ID     = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  core_csr_regfile_if.slave    csr_bus,
  input  logic                 cmt_mstatus_en,
  input  logic                 cmt_mcause_en,
  input  logic                 cmt_mepc_en,
  input  logic [XLEN-1:0]      cmt_mcause,
  input  logic [PC_WIDTH-1:0]  cmt_mepc,
  input  logic                 mret_en,
  input  logic                 instr_retire,
  output logic [PC_WIDTH-1:0]  csr_mtvec,
  output logic [PC_WIDTH-1:0]  csr_mepc,
  output logic                 csr_mie
);

  localparam logic [XLEN-1:0]     XAlignMask  = ~XLEN'(3);
  localparam logic [PC_WIDTH-1:0] PcAlignMask = ~PC_WIDTH'(3);

  logic                mie_q, mie_d;
  logic                mpie_q, mpie_d;
  logic [XLEN-1:0]     mtvec_q, mtvec_d;
  logic [XLEN-1:0]     mscratch_q, mscratch_d;
  logic [PC_WIDTH-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0]     mcause_q, mcause_d;
  logic [63:0]         mcycle, minstret;

  logic            access, implemented, illegal, csr_we;
  logic [XLEN-1:0] mstatus_rd, old_val, new_val;
  csr_op_e         op;

  assign op     = csr_op_e'(csr_bus.csr_op);
  assign access = csr_bus.csr_rd_en | csr_bus.csr_wr_en;

  always_comb begin
    mstatus_rd                            = '0;
    mstatus_rd[MstatusMieBit]             = mie_q;
    mstatus_rd[MstatusMpieBit]            = mpie_q;
    mstatus_rd[MstatusMppHi:MstatusMppLo] = 2'b11;
  end

  // Read mux; also the "old" operand of RS/RC.
  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    case (csr_bus.csr_addr)
      CsrMstatus:   old_val = mstatus_rd;
      CsrMisa:      old_val = XLEN'(MisaValue);
      CsrMtvec:     old_val = mtvec_q;
      CsrMscratch:  old_val = mscratch_q;
      CsrMepc:      old_val = XLEN'(mepc_q);
      CsrMcause:    old_val = mcause_q;
      CsrMcycle:    old_val = XLEN'(mcycle[31:0]);
      CsrMcycleh:   old_val = XLEN'(mcycle[63:32]);
      CsrMinstret:  old_val = XLEN'(minstret[31:0]);
      CsrMinstreth: old_val = XLEN'(minstret[63:32]);
      CsrMhartid:   old_val = HART_ID;
      default:      implemented = 1'b0;
    endcase
  end

  assign illegal = access &
                   (~implemented | (csr_bus.csr_wr_en & (csr_bus.csr_addr == CsrMhartid)));

  assign csr_bus.csr_illegal = illegal;
  assign csr_bus.csr_rdata   = (access & ~illegal) ? old_val : '0;

  assign csr_we = csr_bus.csr_wr_en & (op != CsrOpNone) & ~illegal;

  always_comb begin
    new_val = old_val;
    unique case (op)
      CsrOpRw: new_val = csr_bus.csr_wdata;
      CsrOpRs: new_val = old_val | csr_bus.csr_wdata;
      CsrOpRc: new_val = old_val & ~csr_bus.csr_wdata;
      default: new_val = old_val;
    endcase
  end

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;

    if (cmt_mstatus_en) begin
      mpie_d = mie_q;
      mie_d  = 1'b0;
    end else if (mret_en) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (csr_we && (csr_bus.csr_addr == CsrMstatus)) begin
      mie_d  = new_val[MstatusMieBit];
      mpie_d = new_val[MstatusMpieBit];
    end

    if (csr_we && (csr_bus.csr_addr == CsrMtvec)) mtvec_d = new_val & XAlignMask;
    if (csr_we && (csr_bus.csr_addr == CsrMscratch)) mscratch_d = new_val;

    if (cmt_mepc_en) begin
      mepc_d = cmt_mepc & PcAlignMask;
    end else if (csr_we && (csr_bus.csr_addr == CsrMepc)) begin
      mepc_d = PC_WIDTH'(new_val) & PcAlignMask;
    end

    if (cmt_mcause_en) begin
      mcause_d = cmt_mcause;
    end else if (csr_we && (csr_bus.csr_addr == CsrMcause)) begin
      mcause_d = new_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RESET & XAlignMask;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  core_csr_counter64 u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && (csr_bus.csr_addr == CsrMcycle)),
    .wr_hi_i (csr_we && (csr_bus.csr_addr == CsrMcycleh)),
    .wdata_i (new_val[31:0]),
    .cnt_o   (mcycle)
  );

  core_csr_counter64 u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (instr_retire),
    .wr_lo_i (csr_we && (csr_bus.csr_addr == CsrMinstret)),
    .wr_hi_i (csr_we && (csr_bus.csr_addr == CsrMinstreth)),
    .wdata_i (new_val[31:0]),
    .cnt_o   (minstret)
  );

  assign csr_mtvec = PC_WIDTH'(mtvec_q);
  assign csr_mepc  = mepc_q;
  assign csr_mie   = mie_q;

endmodule
